// File: rtl/trig_record_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trig_record_fifo
// Description : Timestamps rising edges of trigger-path firings and queues
//               {mask, timestamp} records in a small FIFO for readout.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_record_fifo #(
    parameter int NTRIG = 8,
    parameter int TS_W  = 56,
    parameter int DEPTH = 8,
    parameter int OVF_W = 16
) (
    input  logic                      clk_adc,
    input  logic                      nrst,
    input  logic [NTRIG-1:0]          fired,
    input  logic                      resetClock,
    input  logic                      resetOut,
    input  logic                      rd_req,
    output logic [NTRIG+TS_W-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [OVF_W-1:0]          ovf_count,
    output logic [NTRIG-1:0]          triggerFired,
    output logic [TS_W-1:0]           clockCounter
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = NTRIG + TS_W;

    localparam logic [AW:0]      c_cnt_one  = (AW+1)'(1);
    localparam logic [AW:0]      c_cnt_full = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    c_ptr_one  = AW'(1);
    localparam logic [TS_W-1:0]  c_ts_one   = TS_W'(1);
    localparam logic [OVF_W-1:0] c_ovf_one  = OVF_W'(1);

    logic [TS_W-1:0]  r_ts;
    logic [NTRIG-1:0] r_fired_d;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [RW-1:0]    r_mem [DEPTH];

    logic [NTRIG-1:0] w_new;
    logic             w_capture;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [RW-1:0]    w_record;

    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == c_cnt_full);

    assign w_new     = fired & ~r_fired_d;
    assign w_capture = |w_new;
    assign w_record  = {w_new, r_ts};

    // resetOut discards any same-cycle capture or pop; a full FIFO still
    // accepts a record when a pop frees the head slot in the same cycle.
    assign w_pop  = rd_req & ~empty & ~resetOut;
    assign w_push = w_capture & ~resetOut & (~full | w_pop);
    assign w_drop = w_capture & ~resetOut & full & ~w_pop;

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            r_ts      <= '0;
            r_fired_d <= '0;
        end else begin
            r_fired_d <= fired;
            r_ts      <= resetClock ? '0 : r_ts + c_ts_one;
        end
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            ovf_count    <= '0;
            triggerFired <= '0;
            clockCounter <= '0;
        end else begin
            rd_valid <= w_pop;
            if (resetOut) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
                overflow     <= 1'b0;
                ovf_count    <= '0;
                triggerFired <= '0;
                clockCounter <= '0;
            end else begin
                if (w_capture) begin
                    triggerFired <= w_new;
                    clockCounter <= r_ts;
                end
                if (w_pop) begin
                    rd_data  <= r_mem[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_drop) begin
                    overflow <= 1'b1;
                    if (ovf_count != '1) begin
                        ovf_count <= ovf_count + c_ovf_one;
                    end
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: only slots behind the write pointer are read.
    always_ff @(posedge clk_adc) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_record;
        end
    end

endmodule
`default_nettype wire
